// File: rtl/traffic_light_pkg.sv
// Shared light encodings, monitor phase enum and fault codes for the
// traffic light controller/monitor pair.
package traffic_light_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    PH_SYNC   = 2'd0,
    PH_RED    = 2'd1,
    PH_GREEN  = 2'd2,
    PH_YELLOW = 2'd3
  } phase_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ENCODING = 3'd1;
  localparam logic [2:0] FC_ORDER    = 3'd2;
  localparam logic [2:0] FC_SHORT    = 3'd3;
  localparam logic [2:0] FC_LONG     = 3'd4;

  function automatic logic is_one_hot(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
  endfunction

  // Successor in the R-G-Y cycle; SYNC leads into RED.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_RED;
    endcase
  endfunction

  // Light value that corresponds to a phase; SYNC has none.
  function automatic logic [2:0] phase_light(input phase_e p);
    case (p)
      PH_RED:    return LIGHT_RED;
      PH_GREEN:  return LIGHT_GREEN;
      PH_YELLOW: return LIGHT_YELLOW;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/traffic_dwell_counter.sv
// Dwell counter: counts consecutive samples of the current phase and
// compares against the required dwell for that phase.
module traffic_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_to_one,
  input  logic             hold,
  input  logic [CNT_W-1:0] expected,
  output logic             eq,
  output logic             over
);

  logic [CNT_W-1:0] r_count;

  // Load 1 on a new phase, freeze on hold, otherwise count up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear_to_one) begin
      r_count <= CNT_W'(1);
    end else if (!hold) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign eq   = (r_count == expected);
  assign over = (r_count > expected);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light bus: tracks R-G-Y order and dwell,
// latches the first violation and counts completed cycles.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = 5,
  parameter int GREEN_CYCLES  = 4,
  parameter int YELLOW_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  light,
  output logic [1:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        cycle_done,
  output logic [15:0] cycle_count
);

  phase_e      r_phase;
  logic        r_first_red;
  logic        r_fault;
  logic [2:0]  r_fault_code;
  logic        r_cycle_done;
  logic [15:0] r_cycle_count;

  logic [CNT_W-1:0] w_expected;
  logic             w_eq;
  logic             w_over;
  logic [2:0]       w_code;
  logic             w_enter_red;
  logic             w_advance;
  logic             w_stay;
  logic [2:0]       w_cur_light;
  logic [2:0]       w_next_light;

  // Classify the current sample against the tracked phase.
  always_comb begin
    w_expected   = '0;
    w_code       = FC_NONE;
    w_enter_red  = 1'b0;
    w_advance    = 1'b0;
    w_stay       = 1'b0;
    w_cur_light  = phase_light(r_phase);
    w_next_light = phase_light(next_phase(r_phase));
    case (r_phase)
      PH_RED:    w_expected = CNT_W'(RED_CYCLES);
      PH_GREEN:  w_expected = CNT_W'(GREEN_CYCLES);
      PH_YELLOW: w_expected = CNT_W'(YELLOW_CYCLES);
      default:   w_expected = '0;
    endcase
    if (!is_one_hot(light)) begin
      w_code = FC_ENCODING;
    end else if (r_phase == PH_SYNC) begin
      w_enter_red = (light == LIGHT_RED);
    end else if (light == w_cur_light) begin
      // Dwell already at the requirement: one more sample is too long.
      if (w_eq || w_over) w_code = FC_LONG;
      else                w_stay = 1'b1;
    end else if (light == w_next_light) begin
      // The partial RED seen right after SYNC is exempt from the short check.
      if (!(w_eq || w_over) && !r_first_red) w_code = FC_SHORT;
      else                                   w_advance = 1'b1;
    end else begin
      w_code = FC_ORDER;
    end
  end

  traffic_dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk          (clk),
    .reset        (reset),
    .clear_to_one (!r_fault && (w_enter_red || w_advance)),
    .hold         (r_fault || !w_stay),
    .expected     (w_expected),
    .eq           (w_eq),
    .over         (w_over)
  );

  // Phase FSM, sticky fault latch and saturating cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= PH_SYNC;
      r_first_red   <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= FC_NONE;
      r_cycle_done  <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_cycle_done <= 1'b0;
      if (!r_fault) begin
        if (w_code != FC_NONE) begin
          r_fault      <= 1'b1;
          r_fault_code <= w_code;
        end else if (w_enter_red) begin
          r_phase     <= PH_RED;
          r_first_red <= 1'b1;
        end else if (w_advance) begin
          r_phase     <= next_phase(r_phase);
          r_first_red <= 1'b0;
          if (r_phase == PH_YELLOW) begin
            r_cycle_done <= 1'b1;
            if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 16'd1;
          end
        end
      end
    end
  end

  assign phase       = r_phase;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign cycle_done  = r_cycle_done;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: the driver pushes the
// reference model's expected outputs per sample, a monitor pops and compares.
module tb_traffic_light_monitor;

  localparam int RC = 5;
  localparam int GC = 4;
  localparam int YC = 2;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  light;
  logic [1:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic        cycle_done;
  logic [15:0] cycle_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  ph;
    logic        f;
    logic [2:0]  code;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  // Reference model state: current light being held (0 = not yet synced)
  logic [2:0]  m_cur;
  int          m_run;
  bit          m_first;
  bit          m_fault;
  logic [2:0]  m_code;
  bit          m_done;
  int          m_count;

  traffic_light_monitor #(
    .RED_CYCLES    (RC),
    .GREEN_CYCLES  (GC),
    .YELLOW_CYCLES (YC),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .light       (light),
    .phase       (phase),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int req(input logic [2:0] l);
    if (l == R) return RC;
    if (l == G) return GC;
    return YC;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] l);
    if (l == R) return G;
    if (l == G) return Y;
    return R;
  endfunction

  function automatic logic [1:0] ph_of(input logic [2:0] l);
    if (l == R) return 2'd1;
    if (l == G) return 2'd2;
    if (l == Y) return 2'd3;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_cur = 3'b000; m_run = 0; m_first = 0; m_fault = 0;
    m_code = 3'd0; m_done = 0; m_count = 0;
  endtask

  task automatic raise(input logic [2:0] c);
    m_fault = 1; m_code = c;
  endtask

  task automatic model_step(input logic [2:0] l);
    m_done = 0;
    if (m_fault) return;
    if ($countones(l) != 1) raise(3'd1);
    else if (m_cur == 3'b000) begin
      if (l == R) begin m_cur = R; m_run = 1; m_first = 1; end
    end else if (l == m_cur) begin
      if (m_run + 1 > req(m_cur)) raise(3'd4);
      else m_run++;
    end else if (l == succ(m_cur)) begin
      if (m_run < req(m_cur) && !m_first) raise(3'd3);
      else begin
        if (m_cur == Y) begin
          m_done = 1;
          if (m_count < 65535) m_count++;
        end
        m_first = 0; m_cur = l; m_run = 1;
      end
    end else raise(3'd2);
  endtask

  // Drive n samples of l (entered and left at a falling edge).
  task automatic drive(input logic [2:0] l, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      light = l;
      model_step(l);
      e.ph = ph_of(m_cur); e.f = m_fault; e.code = m_code;
      e.done = m_done; e.cnt = 16'(m_count);
      q.push_back(e);
      @(negedge clk);
    end
  endtask

  // Asynchronous reset in the middle of the high clock phase.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_phase", 32'(phase), 0);
    check("async_fault", 32'(fault), 0);
    check("async_code",  32'(fault_code), 0);
    check("async_done",  32'(cycle_done), 0);
    check("async_count", 32'(cycle_count), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every edge yields an output; compare against queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("phase",       32'(phase),       32'(e.ph));
        check("fault",       32'(fault),       32'(e.f));
        check("fault_code",  32'(fault_code),  32'(e.code));
        check("cycle_done",  32'(cycle_done),  32'(e.done));
        check("cycle_count", 32'(cycle_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [2:0] cur;
    int d;
    int r;
    reset = 1'b1;
    light = 3'b000;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_phase", 32'(phase), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_code",  32'(fault_code), 0);
    check("rst_done",  32'(cycle_done), 0);
    check("rst_count", 32'(cycle_count), 0);
    reset = 1'b0;

    // Nominal two full cycles
    drive(R, 5); drive(G, 4); drive(Y, 2); drive(R, 5); drive(G, 4); drive(Y, 2); drive(R, 1);
    check("nominal_count", 32'(cycle_count), 2);
    check("nominal_fault", 32'(fault), 0);

    // Short GREEN, then sticky under illegal encodings, then async reset
    do_reset();
    drive(R, 5); drive(G, 3); drive(Y, 1);
    check("short_code", 32'(fault_code), 3);
    drive(3'b111, 3);
    check("sticky_code", 32'(fault_code), 3);
    do_reset();
    drive(G, 1);
    check("resync_phase", 32'(phase), 0);

    // Long GREEN
    do_reset();
    drive(R, 5); drive(G, 5);
    check("long_code", 32'(fault_code), 4);

    // Bad order, bad encoding, zero in SYNC
    do_reset();
    drive(R, 5); drive(Y, 1);
    check("order_code", 32'(fault_code), 2);
    do_reset();
    drive(R, 2); drive(3'b110, 1);
    check("enc_code", 32'(fault_code), 1);
    do_reset();
    drive(3'b000, 1);
    check("sync_zero_code", 32'(fault_code), 1);

    // Sync entry with partial first RED
    do_reset();
    drive(G, 2); drive(Y, 1); drive(R, 3); drive(G, 4); drive(Y, 2); drive(R, 5);
    drive(G, 4); drive(Y, 2); drive(R, 1);
    check("sync_entry_count", 32'(cycle_count), 2);
    check("sync_entry_fault", 32'(fault), 0);

    // Randomized runs with occasional dwell errors and glitches
    for (int run = 0; run < 25; run++) begin
      do_reset();
      for (int k = 0; k < $urandom_range(0, 3); k++)
        drive(($urandom_range(0, 1) == 0) ? G : Y, 1);
      cur = R;
      drive(R, $urandom_range(1, RC));
      cur = G;
      for (int p = 0; p < 15 && !m_fault; p++) begin
        d = req(cur);
        r = $urandom_range(0, 11);
        if (r == 0 && d > 1) d--;
        else if (r == 1) d++;
        drive(cur, d);
        if (r == 2) drive(3'($urandom_range(0, 7)), 1);
        cur = succ(cur);
      end
      drive(3'($urandom_range(0, 7)), 2);
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
